alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU (ADD/AND/XOR/SRA) between two requesters, e.g. the integer execute path (port 0) and a debug/CSR helper (port 1).
- Arbitrates requests round-robin and registers the operands into the ALU.
- Captures the ALU result and returns it on a valid/ready response channel to the granted requester.
- Sits directly in front of the ALU instance; the ALU's operand and control inputs are driven only from this block's registers.

Parameters:
- XLEN, 32, operand/result width; must match the ALU instance.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester request valid; bit i = requester i
- req_ready  out  2  per-requester request accept; at most one bit high
- req_a  in  2*XLEN  operand A; slice [i*XLEN +: XLEN] = requester i
- req_b  in  2*XLEN  operand B, same packing
- req_op  in  8  ALU control; slice [i*4 +: 4] = requester i
- resp_valid  out  2  per-requester response valid; at most one bit high
- resp_ready  in  2  per-requester response accept
- resp_result  out  XLEN  captured result, shared by both requesters
- resp_zero  out  1  captured zero flag
- alu_a  out  XLEN  to ALU a
- alu_b  out  XLEN  to ALU b
- alu_ctrl  out  4  to ALU alu_ctrl
- alu_result  in  XLEN  from ALU result
- alu_zero  in  1  from ALU zero
- busy  out  1  high in EXEC or RESP
- owner  out  1  index of the current or last granted requester

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; req_ready=0, resp_valid=0, resp_result=0, resp_zero=0, alu_a=0, alu_b=0, alu_ctrl=0, owner=0, busy=0. Priority pointer = requester 0.
- States:
  - IDLE: no operation in flight.
  - EXEC: operands are presented to the ALU for one cycle.
  - RESP: result is held until accepted.
- IDLE:
  - req_ready is combinational: if only one requester is valid, it gets ready; if both are valid, the one selected by the priority pointer gets ready.
  - req_ready is 0 for both requesters outside IDLE.
  - On handshake (valid & ready) at edge E0: latch the winner's a/b/op into alu_a/alu_b/alu_ctrl, set owner=winner, go to EXEC.
- EXEC (one cycle): at edge E1, capture alu_result into resp_result and alu_zero into resp_zero, go to RESP.
- RESP:
  - resp_valid[owner]=1; resp_result and resp_zero are held stable.
  - On resp_ready[owner] at any edge: go to IDLE and set the priority pointer to the other requester (~owner).
  - resp_ready of the non-owner is ignored.
- Latency: accept at E0 -> resp_valid high after E1, i.e. 2 cycles.
- Minimum issue interval is 3 cycles: accept, exec, response with immediate ready.
- A new request cannot be accepted in the same cycle a response completes; it is accepted in the following IDLE cycle.
- alu_a/alu_b/alu_ctrl hold their last values outside EXEC; they are not cleared.
- Op codes pass through unmodified: 0 ADD, 1 AND, 2 XOR, 3 SRA (shift amount b[4:0]); any other code yields result 0 and zero=1, as the ALU defines.
- A requester must hold valid and its operands stable until ready. Dropping valid before ready is permitted: there is no acceptance and no side effect.
- Fairness: under continuous requests from both requesters, grants strictly alternate 0,1,0,1...
- Reset mid-operation, in EXEC or RESP: the in-flight operation is discarded and no response is issued. After release, the first grant goes to requester 0.
- Invariants: never two bits of req_ready high; never two bits of resp_valid high; busy = (state != IDLE).

Test Plan:
1. Reset, then requester 0 sends a=5, b=7, op=0; resp_ready held 1 -> req_ready[0] pulses 1 cycle; resp_valid[0] high 2 cycles after accept with resp_result=12, resp_zero=0; busy high for 2 cycles.
2. Requester 1 sends a=0xF0F0F0F0, b=0xF0F0F0F0, op=2 (XOR) -> resp_result=0, resp_zero=1, resp_valid[1] only; owner=1.
3. Requester 0 sends a=0x80000000, b=4, op=3 (SRA) -> resp_result=0xF8000000; then op=7 -> resp_result=0, resp_zero=1.
4. Both requesters valid continuously for 6 operations (req0: a=1, b=1, ADD; req1: a=3, b=1, AND) -> grant order 0,1,0,1,0,1; results alternate 2,1; never two ready bits high.
5. Response backpressure: resp_ready[owner]=0 for 5 cycles while the other requester is valid -> resp_valid and resp_result stay stable; no new req_ready; the other requester is granted the cycle after release.
6. Assert rst_n low during EXEC of a=9, b=9, ADD -> outputs return to reset values immediately; no resp_valid for that operation; the next request from requester 1 (with requester 0 also valid) is granted to requester 0 first.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two requesters and the shared-ALU arbiter.
//   req_valid/req_ready : per-requester request handshake (bit i = requester i)
//   req_a/req_b         : operands, slice [i*XLEN +: XLEN] = requester i
//   req_op              : ALU control, slice [i*4 +: 4] = requester i
//   resp_valid/ready    : per-requester response handshake
//   resp_result/zero    : captured ALU result and zero flag, shared by both
interface alu_share_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned NREQ = 2;
  localparam int unsigned OPW  = 4;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*XLEN-1:0] req_a;
  logic [NREQ*XLEN-1:0] req_b;
  logic [NREQ*OPW-1:0]  req_op;
  logic [NREQ-1:0]      resp_valid;
  logic [NREQ-1:0]      resp_ready;
  logic [XLEN-1:0]      resp_result;
  logic                 resp_zero;

  // Requester side
  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_zero
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_result, resp_zero
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// A granted request has its operands registered onto the ALU inputs for one
// cycle (EXEC), the ALU output is captured, and it is returned on the
// requester's response channel (RESP) until accepted.
//   clk, rst_n         : clock, asynchronous active-low reset
//   bus (slave)        : request/response bundle, see alu_share_arbiter_if
//   alu_a/alu_b/ctrl   : registered ALU operands and control
//   alu_result/zero    : ALU outputs
//   busy               : operation in flight (EXEC or RESP)
//   owner              : current or last granted requester
module alu_share_arbiter #(
  parameter int unsigned XLEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_share_arbiter_if.slave  bus,
  output logic [XLEN-1:0]     alu_a,
  output logic [XLEN-1:0]     alu_b,
  output logic [3:0]          alu_ctrl,
  input  logic [XLEN-1:0]     alu_result,
  input  logic                alu_zero,
  output logic                busy,
  output logic                owner
);

  localparam int unsigned OPW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   prio_q, prio_d;
  logic   win_c;
  logic   accept_c;
  logic   capture_c;

  // State and priority pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  // Next state, arbitration and handshake decode
  always_comb begin
    state_d        = state_q;
    prio_d         = prio_q;
    win_c          = 1'b0;
    accept_c       = 1'b0;
    capture_c      = 1'b0;
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    case (state_q)
      IDLE: begin
        // Lone requester wins; on contention the pointer decides
        case (bus.req_valid)
          2'b01:   win_c = 1'b0;
          2'b10:   win_c = 1'b1;
          2'b11:   win_c = prio_q;
          default: win_c = 1'b0;
        endcase
        // Ready follows valid, so any valid request is accepted this cycle
        if (|bus.req_valid) begin
          bus.req_ready[win_c] = 1'b1;
          accept_c             = 1'b1;
          state_d              = EXEC;
        end
      end
      EXEC: begin
        capture_c = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        bus.resp_valid[owner] = 1'b1;
        // Only the owner's ready completes the response
        if (bus.resp_ready[owner]) begin
          state_d = IDLE;
          prio_d  = ~owner;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand launch and result capture; ALU inputs hold outside EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a           <= '0;
      alu_b           <= '0;
      alu_ctrl        <= '0;
      owner           <= 1'b0;
      bus.resp_result <= '0;
      bus.resp_zero   <= 1'b0;
    end else begin
      if (accept_c) begin
        alu_a    <= win_c ? bus.req_a[2*XLEN-1:XLEN] : bus.req_a[XLEN-1:0];
        alu_b    <= win_c ? bus.req_b[2*XLEN-1:XLEN] : bus.req_b[XLEN-1:0];
        alu_ctrl <= win_c ? bus.req_op[2*OPW-1:OPW] : bus.req_op[OPW-1:0];
        owner    <= win_c;
      end
      if (capture_c) begin
        bus.resp_result <= alu_result;
        bus.resp_zero   <= alu_zero;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached.
module tb_alu_share_arbiter;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic            busy;
  logic            owner;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter_if #(.XLEN(XLEN)) bus ();

  alu_share_arbiter #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .busy       (busy),
    .owner      (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: ADD, AND, XOR, SRA; other codes give 0
  always_comb begin
    case (alu_ctrl)
      4'd0:    alu_result = alu_a + alu_b;
      4'd1:    alu_result = alu_a & alu_b;
      4'd2:    alu_result = alu_a ^ alu_b;
      4'd3:    alu_result = XLEN'($signed(alu_a) >>> alu_b[4:0]);
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int port, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
    bus.req_a[port*XLEN +: XLEN] = a;
    bus.req_b[port*XLEN +: XLEN] = b;
    bus.req_op[port*4 +: 4]      = op;
  endtask

  // Invariants sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_onehot", 64'($countones(bus.req_ready) <= 1), 64'd1);
      check("resp_onehot", 64'($countones(bus.resp_valid) <= 1), 64'd1);
      if (bus.resp_valid != 2'b00) check("busy_in_resp", 64'(busy), 64'd1);
    end
  end

  // Single-requester transaction from IDLE with resp_ready held high
  task automatic do_op(input int port, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [31:0] er, input logic ez);
    logic [1:0] oh;
    oh = 2'(1 << port);
    set_req(port, a, b, op);
    bus.req_valid = oh;
    #1;
    check("op_grant", 64'(bus.req_ready), 64'(oh));
    check("op_idle_busy", 64'(busy), 64'd0);
    step();
    bus.req_valid = 2'b00;
    #1;
    check("exec_ready", 64'(bus.req_ready), 64'd0);
    check("exec_busy", 64'(busy), 64'd1);
    check("exec_alu_a", 64'(alu_a), 64'(a));
    check("exec_alu_b", 64'(alu_b), 64'(b));
    check("exec_alu_ctrl", 64'(alu_ctrl), 64'(op));
    check("exec_owner", 64'(owner), 64'(port));
    check("exec_resp_valid", 64'(bus.resp_valid), 64'd0);
    step();
    check("resp_valid", 64'(bus.resp_valid), 64'(oh));
    check("resp_result", 64'(bus.resp_result), 64'(er));
    check("resp_zero", 64'(bus.resp_zero), 64'(ez));
    check("resp_busy", 64'(busy), 64'd1);
    step();
    check("done_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("done_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_op     = '0;
    bus.resp_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_result", 64'(bus.resp_result), 64'd0);
    check("rst_resp_zero", 64'(bus.resp_zero), 64'd0);
    check("rst_alu_a", 64'(alu_a), 64'd0);
    check("rst_alu_b", 64'(alu_b), 64'd0);
    check("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    check("rst_owner", 64'(owner), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    step();
    bus.resp_ready = 2'b11;

    // Single-requester operations
    do_op(0, 32'd5, 32'd7, 4'd0, 32'd12, 1'b0);
    do_op(1, 32'hF0F0F0F0, 32'hF0F0F0F0, 4'd2, 32'd0, 1'b1);
    do_op(0, 32'h80000000, 32'd4, 4'd3, 32'hF8000000, 1'b0);
    do_op(0, 32'd5, 32'd3, 4'd7, 32'd0, 1'b1);
    // Last grant to requester 1 so contention starts at requester 0
    do_op(1, 32'h0000FF00, 32'h000000FF, 4'd1, 32'd0, 1'b1);

    // Continuous contention: grants alternate 0,1,0,1,0,1
    set_req(0, 32'd1, 32'd1, 4'd0);
    set_req(1, 32'd3, 32'd1, 4'd1);
    bus.req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("rr_grant", 64'(bus.req_ready), (i % 2 == 1) ? 64'd2 : 64'd1);
      step();
      check("rr_exec_ready", 64'(bus.req_ready), 64'd0);
      check("rr_owner", 64'(owner), 64'(i % 2));
      step();
      check("rr_resp_valid", 64'(bus.resp_valid), (i % 2 == 1) ? 64'd2 : 64'd1);
      check("rr_result", 64'(bus.resp_result), (i % 2 == 1) ? 64'd1 : 64'd2);
      step();
    end

    // Backpressure on requester 0; non-owner ready must be ignored
    bus.resp_ready = 2'b10;
    #1;
    check("bp_grant", 64'(bus.req_ready), 64'd1);
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      check("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
      check("bp_result", 64'(bus.resp_result), 64'd2);
      check("bp_zero", 64'(bus.resp_zero), 64'd0);
      check("bp_no_ready", 64'(bus.req_ready), 64'd0);
      step();
    end
    bus.resp_ready = 2'b01;
    #1;
    check("bp_release_valid", 64'(bus.resp_valid), 64'd1);
    check("bp_release_ready", 64'(bus.req_ready), 64'd0);
    step();
    check("bp_next_grant", 64'(bus.req_ready), 64'd2);
    bus.resp_ready = 2'b11;
    step();
    step();
    check("bp_next_resp", 64'(bus.resp_valid), 64'd2);
    check("bp_next_result", 64'(bus.resp_result), 64'd1);
    step();
    bus.req_valid = 2'b00;

    // Leave priority pointing at requester 1, then reset mid-EXEC
    do_op(0, 32'h10, 32'h01, 4'd1, 32'd0, 1'b1);
    set_req(1, 32'd9, 32'd9, 4'd0);
    bus.req_valid = 2'b10;
    #1;
    check("mr_grant", 64'(bus.req_ready), 64'd2);
    step();
    check("mr_exec_alu_a", 64'(alu_a), 64'd9);
    check("mr_exec_busy", 64'(busy), 64'd1);
    rst_n         = 1'b0;
    bus.req_valid = 2'b00;
    #1;
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_alu_a", 64'(alu_a), 64'd0);
    check("mr_alu_b", 64'(alu_b), 64'd0);
    check("mr_alu_ctrl", 64'(alu_ctrl), 64'd0);
    check("mr_owner", 64'(owner), 64'd0);
    check("mr_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("mr_resp_result", 64'(bus.resp_result), 64'd0);
    check("mr_req_ready", 64'(bus.req_ready), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("mr_no_resp", 64'(bus.resp_valid), 64'd0);
    check("mr_idle", 64'(busy), 64'd0);
    set_req(0, 32'd1, 32'd1, 4'd0);
    bus.req_valid = 2'b11;
    #1;
    check("mr_first_grant", 64'(bus.req_ready), 64'd1);
    step();
    check("mr_first_owner", 64'(owner), 64'd0);
    step();
    check("mr_first_resp", 64'(bus.resp_valid), 64'd1);
    check("mr_first_result", 64'(bus.resp_result), 64'd2);
    step();
    bus.req_valid = 2'b00;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
